// File: rtl/mac_tx_frame_arbiter.sv
// Frame-level round-robin arbiter: locks one requester onto the MAC TX byte stream per frame,
// inserts an idle gap between frames and truncates frames longer than MAX_BEATS.
module mac_tx_frame_arbiter #(
  parameter int N_REQ     = 3,
  parameter int MAX_BEATS = 1514,
  parameter int MIN_GAP   = 12
) (
  input  logic               clk,
  input  logic               logic_rst,
  input  logic [N_REQ*8-1:0] req_data_in,
  input  logic [N_REQ-1:0]   req_valid_in,
  input  logic [N_REQ-1:0]   req_last_in,
  output logic [N_REQ-1:0]   req_ready_out,
  output logic [7:0]         mac_tx_data_out,
  output logic               mac_tx_valid_out,
  output logic               mac_tx_last_out,
  input  logic               mac_tx_ready_in,
  output logic [N_REQ-1:0]   grant_out,
  output logic               busy_out,
  output logic               frame_err_out
);

  localparam int PW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int GW = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, GAP} state_t;

  // With no gap configured a finished frame returns straight to arbitration.
  localparam state_t FRAME_END = (MIN_GAP == 0) ? IDLE : GAP;

  state_t           state, state_nxt;
  logic [PW-1:0]    rr_ptr, rr_ptr_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [BW-1:0]    beat_cnt, beat_cnt_nxt;
  logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
  logic             frame_err_nxt;

  logic             found_hi, found_lo, win_found;
  logic [PW-1:0]    idx_hi, idx_lo, win_idx;
  logic [7:0]       sel_data;
  logic             sel_valid, sel_last;
  logic             beat_at_max;

  // Round-robin search: lowest valid index above rr_ptr, else lowest at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid_in[i]) begin
        if (PW'(i) > rr_ptr) begin
          found_hi = 1'b1;
          idx_hi   = PW'(i);
        end else begin
          found_lo = 1'b1;
          idx_lo   = PW'(i);
        end
      end
    end
    win_found = found_hi | found_lo;
    win_idx   = found_hi ? idx_hi : idx_lo;
  end

  // rr_ptr always holds the current owner while a frame is in flight.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_ptr == PW'(i)) begin
        sel_data  = req_data_in[8*i +: 8];
        sel_valid = req_valid_in[i];
        sel_last  = req_last_in[i];
      end
    end
  end

  assign beat_at_max = (beat_cnt == BW'(MAX_BEATS - 1));
  assign busy_out    = (state != IDLE);

  always_ff @(posedge clk or posedge logic_rst) begin
    if (logic_rst) begin
      state         <= IDLE;
      rr_ptr        <= PW'(N_REQ - 1);
      grant_out     <= '0;
      beat_cnt      <= '0;
      gap_cnt       <= '0;
      frame_err_out <= 1'b0;
    end else begin
      state         <= state_nxt;
      rr_ptr        <= rr_ptr_nxt;
      grant_out     <= grant_nxt;
      beat_cnt      <= beat_cnt_nxt;
      gap_cnt       <= gap_cnt_nxt;
      frame_err_out <= frame_err_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    rr_ptr_nxt       = rr_ptr;
    grant_nxt        = grant_out;
    beat_cnt_nxt     = beat_cnt;
    gap_cnt_nxt      = gap_cnt;
    frame_err_nxt    = 1'b0;
    req_ready_out    = '0;
    mac_tx_data_out  = '0;
    mac_tx_valid_out = 1'b0;
    mac_tx_last_out  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_nxt    = N_REQ'(1) << win_idx;
          rr_ptr_nxt   = win_idx;
          beat_cnt_nxt = '0;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        mac_tx_data_out  = sel_data;
        mac_tx_valid_out = sel_valid;
        mac_tx_last_out  = sel_last | beat_at_max;
        req_ready_out    = mac_tx_ready_in ? grant_out : '0;
        if (sel_valid && mac_tx_ready_in) begin
          if (beat_cnt != BW'(MAX_BEATS)) beat_cnt_nxt = beat_cnt + 1'b1;
          if (sel_last) begin
            state_nxt   = FRAME_END;
            grant_nxt   = '0;
            gap_cnt_nxt = '0;
          end else if (beat_at_max) begin
            frame_err_nxt = 1'b1;
            state_nxt     = DRAIN;
          end
        end
      end
      DRAIN: begin
        req_ready_out = grant_out;
        if (sel_valid && sel_last) begin
          state_nxt   = FRAME_END;
          grant_nxt   = '0;
          gap_cnt_nxt = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(MIN_GAP - 1)) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_tx_frame_arbiter.sv
// Bench for mac_tx_frame_arbiter: three instances (default, MAX_BEATS=16, MIN_GAP=0) driven
// by per-requester frame drivers, checked against per-requester expected-byte queues.
module tb_mac_tx_frame_arbiter;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    int d;
    int r;
    int len;
    bit tog;
    int exp_len;
    int exp_err;
    int exp_gap;
  } vec_t;

  logic       clk = 1'b0;
  logic       logic_rst;
  logic [7:0] rd [3][3];
  logic       rv [3][3];
  logic       rl [3][3];
  logic [23:0] req_data [3];
  logic [2:0]  req_valid [3];
  logic [2:0]  req_last [3];
  logic [2:0]  req_ready [3];
  logic [2:0]  grant [3];
  logic [7:0]  mdata [3];
  logic        mv [3];
  logic        ml [3];
  logic        mr [3];
  logic        busy [3];
  logic        ferr [3];

  beat_t exp_q [3][3][$];
  int    glog [3][$];
  int    err_cnt [3];
  int    gap_run [3];
  int    last_gap [3];
  int    between [3];
  int    last_end [3];
  bit    in_frame [3];
  bit    have_last [3];
  logic [2:0] prev_grant [3];
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      for (int r = 0; r < 3; r++) begin
        req_data[d][8*r +: 8] = rd[d][r];
        req_valid[d][r]       = rv[d][r];
        req_last[d][r]        = rl[d][r];
      end
    end
  end

  for (genvar d = 0; d < 3; d++) begin : g_dut
    mac_tx_frame_arbiter #(
      .N_REQ(3),
      .MAX_BEATS((d == 1) ? 16 : 1514),
      .MIN_GAP((d == 2) ? 0 : 12)
    ) u_dut (
      .clk(clk),
      .logic_rst(logic_rst),
      .req_data_in(req_data[d]),
      .req_valid_in(req_valid[d]),
      .req_last_in(req_last[d]),
      .req_ready_out(req_ready[d]),
      .mac_tx_data_out(mdata[d]),
      .mac_tx_valid_out(mv[d]),
      .mac_tx_last_out(ml[d]),
      .mac_tx_ready_in(mr[d]),
      .grant_out(grant[d]),
      .busy_out(busy[d]),
      .frame_err_out(ferr[d])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  function automatic int oh_idx(input logic [2:0] g);
    for (int i = 0; i < 3; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Output monitor: scoreboard pops, frame spacing, gap length, error pulses, grant order.
  always @(negedge clk) begin
    int g;
    bit ok;
    beat_t e;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (logic_rst) begin
        in_frame[d] = 1'b0;
        have_last[d] = 1'b0;
        gap_run[d] = 0;
        prev_grant[d] = '0;
      end else begin
        if (mv[d] && mr[d]) begin
          g = oh_idx(grant[d]);
          ok = 1'b0;
          if (g >= 0) ok = (exp_q[d][g].size() != 0);
          check("beat_expected", ok, 1);
          check("busy_in_frame", busy[d], 1);
          if (ok) begin
            e = exp_q[d][g].pop_front();
            check("out_data", mdata[d], e.data);
            check("out_last", ml[d], e.last);
          end
          if (!in_frame[d] && have_last[d]) between[d] = cyc - last_end[d] - 1;
          in_frame[d] = 1'b1;
          if (ml[d]) begin
            in_frame[d] = 1'b0;
            have_last[d] = 1'b1;
            last_end[d] = cyc;
          end
        end
        if (ferr[d]) err_cnt[d]++;
        if (busy[d] && grant[d] == 3'b000) gap_run[d]++;
        else if (gap_run[d] != 0) begin
          last_gap[d] = gap_run[d];
          gap_run[d] = 0;
        end
        if (grant[d] != 3'b000 && prev_grant[d] == 3'b000) glog[d].push_back(oh_idx(grant[d]));
        prev_grant[d] = grant[d];
      end
    end
  end

  task automatic send_frame(input int d, input int r, input int len, input int exp_len,
                            input bit tog);
    logic [7:0] dat[$];
    beat_t b;
    int i;
    int guard;
    bit acc;
    for (int k = 0; k < len; k++) begin
      dat.push_back(8'($urandom_range(0, 255)));
      if (k < exp_len) begin
        b.data = dat[k];
        b.last = (k == len - 1) || (k == exp_len - 1);
        exp_q[d][r].push_back(b);
      end
    end
    i = 0;
    guard = 0;
    while (i < len && guard < 2000) begin
      rv[d][r] = 1'b1;
      rd[d][r] = dat[i];
      rl[d][r] = (i == len - 1);
      @(negedge clk);
      acc = req_ready[d][r];
      if (tog && grant[d][r]) check("ready_mirror", req_ready[d][r], mr[d]);
      @(posedge clk);
      #1;
      if (acc) i++;
      if (tog) mr[d] = ~mr[d];
      guard++;
    end
    rv[d][r] = 1'b0;
    rl[d][r] = 1'b0;
    rd[d][r] = '0;
    check("frame_sent", i, len);
  endtask

  task automatic wait_idle(input int d);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy[d] || grant[d] != 3'b000) && k < 1000);
    check("reach_idle", busy[d], 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input int d);
    check("z_grant", grant[d], 0);
    check("z_busy", busy[d], 0);
    check("z_valid", mv[d], 0);
    check("z_data", mdata[d], 0);
    check("z_last", ml[d], 0);
    check("z_ready", req_ready[d], 0);
    check("z_err", ferr[d], 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 logic_rst = 1'b1;
    @(posedge clk);
    #1 logic_rst = 1'b0;
  endtask

  initial begin
    vec_t vt[6];
    int e0;
    int guard;
    bit acc;
    vt[0] = '{0, 0, 60, 1'b0, 60, 0, 12};
    vt[1] = '{0, 1, 64, 1'b1, 64, 0, 12};
    vt[2] = '{1, 2, 20, 1'b0, 16, 1, 12};
    vt[3] = '{1, 1, 16, 1'b0, 16, 0, 12};
    vt[4] = '{1, 0, 17, 1'b0, 16, 1, 12};
    vt[5] = '{0, 2, 1, 1'b0, 1, 0, 12};

    logic_rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      mr[d] = 1'b1;
      err_cnt[d] = 0;
      last_gap[d] = -1;
      between[d] = -1;
      last_end[d] = 0;
      for (int r = 0; r < 3; r++) begin
        rv[d][r] = 1'b0;
        rl[d][r] = 1'b0;
        rd[d][r] = '0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_zero_outputs(d);
    logic_rst = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) check_zero_outputs(d);

    // Single frames: passthrough, ready toggling, truncation, exact-max, single byte.
    for (int v = 0; v < 6; v++) begin
      last_gap[vt[v].d] = -1;
      e0 = err_cnt[vt[v].d];
      send_frame(vt[v].d, vt[v].r, vt[v].len, vt[v].exp_len, vt[v].tog);
      wait_idle(vt[v].d);
      mr[vt[v].d] = 1'b1;
      check("queue_drained", exp_q[vt[v].d][vt[v].r].size(), 0);
      check("err_pulses", err_cnt[vt[v].d] - e0, vt[v].exp_err);
      check("gap_len", last_gap[vt[v].d], vt[v].exp_gap);
    end

    // Round-robin order after reset with all three requesting, then 0 and 2.
    do_reset();
    glog[0].delete();
    fork
      send_frame(0, 0, 10, 10, 1'b0);
      send_frame(0, 1, 10, 10, 1'b0);
      send_frame(0, 2, 10, 10, 1'b0);
    join
    wait_idle(0);
    check("rr3_count", glog[0].size(), 3);
    if (glog[0].size() == 3) begin
      check("rr3_first", glog[0][0], 0);
      check("rr3_second", glog[0][1], 1);
      check("rr3_third", glog[0][2], 2);
    end
    glog[0].delete();
    fork
      send_frame(0, 0, 10, 10, 1'b0);
      send_frame(0, 2, 10, 10, 1'b0);
    join
    wait_idle(0);
    check("rr2_count", glog[0].size(), 2);
    if (glog[0].size() == 2) begin
      check("rr2_first", glog[0][0], 0);
      check("rr2_second", glog[0][1], 2);
    end

    // Reset in the middle of a req1 frame, then req0 must win over req1.
    for (int i = 0; i < 10; i++) begin
      beat_t b;
      b.data = 8'(8'h40 + i);
      b.last = 1'b0;
      exp_q[0][1].push_back(b);
      rv[0][1] = 1'b1;
      rd[0][1] = b.data;
      rl[0][1] = 1'b0;
      guard = 0;
      acc = 1'b0;
      while (!acc && guard < 100) begin
        @(negedge clk);
        acc = req_ready[0][1];
        @(posedge clk);
        #1;
        guard++;
      end
    end
    check("pre_reset_beats_left", exp_q[0][1].size(), 0);
    rd[0][1] = 8'h4a;
    logic_rst = 1'b1;
    #1;
    check_zero_outputs(0);
    exp_q[0][1].delete();
    rv[0][1] = 1'b0;
    rd[0][1] = '0;
    @(posedge clk);
    #1 logic_rst = 1'b0;
    glog[0].delete();
    fork
      send_frame(0, 0, 5, 5, 1'b0);
      send_frame(0, 1, 5, 5, 1'b0);
    join
    wait_idle(0);
    check("post_rst_count", glog[0].size(), 2);
    if (glog[0].size() == 2) begin
      check("post_rst_first", glog[0][0], 0);
      check("post_rst_second", glog[0][1], 1);
    end

    // No gap configured: back-to-back frames separated by exactly one arbitration cycle.
    between[2] = -1;
    glog[2].delete();
    fork
      send_frame(2, 0, 8, 8, 1'b0);
      send_frame(2, 1, 8, 8, 1'b0);
    join
    wait_idle(2);
    check("nogap_between", between[2], 1);
    check("nogap_count", glog[2].size(), 2);
    if (glog[2].size() == 2) begin
      check("nogap_first", glog[2][0], 0);
      check("nogap_second", glog[2][1], 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
